// File: rtl/stream_rr_arbiter_if.sv
// Handshake bundle between the per-input stream buffers and the
// packet round-robin arbiter that drives the output mux select.
interface stream_rr_arbiter_if #(
  parameter int NUM_REQUEST = 4,
  parameter int MAX_BEATS   = 256
);
  localparam int IDX_W = $clog2(NUM_REQUEST);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  logic [NUM_REQUEST-1:0] request_i;
  logic [NUM_REQUEST-1:0] s_last_i;
  logic                   m_ready_i;
  logic [NUM_REQUEST-1:0] grant_o;
  logic [IDX_W-1:0]       grant_idx_o;
  logic                   grant_valid_o;
  logic [CNT_W-1:0]       beat_cnt_o;
  logic                   timeout_o;

  modport slave (
    input  request_i,
    input  s_last_i,
    input  m_ready_i,
    output grant_o,
    output grant_idx_o,
    output grant_valid_o,
    output beat_cnt_o,
    output timeout_o
  );

  modport master (
    output request_i,
    output s_last_i,
    output m_ready_i,
    input  grant_o,
    input  grant_idx_o,
    input  grant_valid_o,
    input  beat_cnt_o,
    input  timeout_o
  );
endinterface

// File: rtl/stream_rr_arbiter.sv
// Packet-locked round-robin arbiter with zero-bubble re-arbitration.
// Optional stall watchdog enabled by STREAM_RR_ARB_TIMEOUT_EN.
module stream_rr_arbiter #(
  parameter int NUM_REQUEST    = 4,
  parameter int MAX_BEATS      = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  stream_rr_arbiter_if.slave arb
);
  localparam int IDX_W = $clog2(NUM_REQUEST);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQUEST - 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                 state_q;
  logic [NUM_REQUEST-1:0] grant_q;
  logic [IDX_W-1:0]       idx_q;
  logic [IDX_W-1:0]       ptr_q;
  logic [CNT_W-1:0]       beat_q;

  logic                   locked;
  logic                   xfer;
  logic                   pkt_end;
  logic                   tmo_rel;
  logic                   release_w;
  logic [IDX_W-1:0]       nxt_ptr;
  logic [IDX_W-1:0]       arb_ptr;
  logic                   pick_vld;
  logic [IDX_W-1:0]       pick_idx;
  logic [CNT_W-1:0]       beat_inc;

  assign locked    = (state_q == LOCKED);
  assign xfer      = locked & arb.request_i[idx_q] & arb.m_ready_i;
  assign pkt_end   = xfer & arb.s_last_i[idx_q];
  assign release_w = pkt_end | tmo_rel;
  assign nxt_ptr   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
  assign arb_ptr   = release_w ? nxt_ptr : ptr_q;
  assign beat_inc  = (beat_q == CNT_W'(MAX_BEATS)) ? beat_q
                                                   : beat_q + 1'b1;

  // Scan upward from the active pointer for the first requester.
  always_comb begin
    logic [IDX_W-1:0] cand;
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = arb_ptr;
    for (int k = 0; k < NUM_REQUEST; k++) begin
      if (!pick_vld && arb.request_i[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
    end
  end

`ifdef STREAM_RR_ARB_TIMEOUT_EN
  localparam int STL_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [STL_W-1:0] stall_q;
  logic             tmo_q;

  assign tmo_rel = locked & ~xfer &
                   (stall_q == STL_W'(TIMEOUT_CYCLES - 1));

  // Count stalled locked cycles; pulse timeout on forced release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_q <= tmo_rel;
      if (!locked || xfer || tmo_rel)
        stall_q <= '0;
      else
        stall_q <= stall_q + 1'b1;
    end
  end

  assign arb.timeout_o = tmo_q;
`else
  assign tmo_rel       = 1'b0;
  assign arb.timeout_o = 1'b0;
`endif

  // Lock FSM: grant on request, hold until packet end, re-arbitrate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      beat_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q <= LOCKED;
            grant_q <= NUM_REQUEST'(1) << pick_idx;
            idx_q   <= pick_idx;
            beat_q  <= '0;
          end
        end
        LOCKED: begin
          if (release_w) begin
            ptr_q  <= nxt_ptr;
            beat_q <= '0;
            if (pick_vld) begin
              grant_q <= NUM_REQUEST'(1) << pick_idx;
              idx_q   <= pick_idx;
            end else begin
              state_q <= IDLE;
              grant_q <= '0;
            end
          end else if (xfer) begin
            beat_q <= beat_inc;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arb.grant_o       = grant_q;
  assign arb.grant_idx_o   = idx_q;
  assign arb.grant_valid_o = locked;
  assign arb.beat_cnt_o    = beat_q;
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Randomized scoreboard bench: a 4-input and a 3-input arbiter
// share stimulus and are checked against a queue-fed reference.
module tb_stream_rr_arbiter;
  localparam int TO   = 8;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_rr_arbiter_if #(.NUM_REQUEST(4), .MAX_BEATS(256)) if4();
  stream_rr_arbiter_if #(.NUM_REQUEST(3), .MAX_BEATS(4))   if3();

  stream_rr_arbiter #(
    .NUM_REQUEST(4), .MAX_BEATS(256), .TIMEOUT_CYCLES(TO)
  ) dut4 (.clk(clk), .rst_n(rst_n), .arb(if4));

  stream_rr_arbiter #(
    .NUM_REQUEST(3), .MAX_BEATS(4), .TIMEOUT_CYCLES(TO)
  ) dut3 (.clk(clk), .rst_n(rst_n), .arb(if3));

  typedef struct {
    int u;
    int grant;
    int idx;
    bit valid;
    int beats;
    bit tmo;
    bit chk_idx;
  } exp_t;

  exp_t q[$];
  int n_chk  = 0;
  int n_fail = 0;

  int m_n[2]   = '{4, 3};
  int m_max[2] = '{256, 4};
  bit m_lock[2];
  int m_idx[2];
  int m_ptr[2];
  int m_beats[2];
  int m_stall[2];
  bit m_tmo[2];

  function automatic int pick(int n, int ptr, logic [3:0] req);
    for (int k = 0; k < n; k++) begin
      int i;
      i = (ptr + k) % n;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step(int u, bit rs, logic [3:0] req,
                            logic [3:0] last, bit rdy);
    int p, o, n;
    bit x, rel, to;
    exp_t e;
    n = m_n[u];
    if (!rs) begin
      m_lock[u] = 0; m_idx[u] = 0; m_ptr[u] = 0;
      m_beats[u] = 0; m_stall[u] = 0; m_tmo[u] = 0;
    end else begin
      m_tmo[u] = 0;
      if (!m_lock[u]) begin
        p = pick(n, m_ptr[u], req);
        if (p >= 0) begin
          m_lock[u] = 1; m_idx[u] = p;
          m_beats[u] = 0; m_stall[u] = 0;
        end
      end else begin
        o   = m_idx[u];
        x   = req[o] && rdy;
        rel = x && last[o];
        to  = 0;
`ifdef STREAM_RR_ARB_TIMEOUT_EN
        if (x) m_stall[u] = 0;
        else if (m_stall[u] + 1 >= TO) to = 1;
        else m_stall[u]++;
`endif
        if (rel || to) begin
          m_ptr[u] = (o + 1) % n;
          m_beats[u] = 0; m_stall[u] = 0; m_tmo[u] = to;
          p = pick(n, m_ptr[u], req);
          if (p >= 0) m_idx[u] = p;
          else m_lock[u] = 0;
        end else if (x && m_beats[u] < m_max[u]) begin
          m_beats[u]++;
        end
      end
    end
    e.u       = u;
    e.valid   = m_lock[u];
    e.grant   = m_lock[u] ? (1 << m_idx[u]) : 0;
    e.idx     = m_idx[u];
    e.beats   = m_beats[u];
    e.tmo     = m_tmo[u];
    e.chk_idx = m_lock[u] || !rs;
    q.push_back(e);
  endtask

  task automatic check(string name, int u, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (N=%0d) at %0t: got %0d expected %0d",
               name, m_n[u], $time, act, exp);
    end
  endtask

  // Monitor: compare registered outputs just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.u == 0) begin
          check("grant", 0, int'(if4.grant_o), e.grant);
          check("valid", 0, int'(if4.grant_valid_o), int'(e.valid));
          check("beats", 0, int'(if4.beat_cnt_o), e.beats);
          check("tmo", 0, int'(if4.timeout_o), int'(e.tmo));
          if (e.chk_idx)
            check("idx", 0, int'(if4.grant_idx_o), e.idx);
        end else begin
          check("grant", 1, int'(if3.grant_o), e.grant);
          check("valid", 1, int'(if3.grant_valid_o), int'(e.valid));
          check("beats", 1, int'(if3.beat_cnt_o), e.beats);
          check("tmo", 1, int'(if3.timeout_o), int'(e.tmo));
          if (e.chk_idx)
            check("idx", 1, int'(if3.grant_idx_o), e.idx);
        end
      end
    end
  end

  // Stimulus: phased random traffic, pushed to the scoreboard.
  initial begin
    logic [3:0] r, l;
    bit rdy, rs;
    int mode, w;
    if4.request_i = '0; if4.s_last_i = '0; if4.m_ready_i = 1'b0;
    if3.request_i = '0; if3.s_last_i = '0; if3.m_ready_i = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      mode = (c / 150) % 5;
      r    = 4'($urandom_range(0, 15));
      l    = 4'($urandom & $urandom);
      rdy  = ($urandom_range(0, 3) != 0);
      unique case (mode)
        1: begin r = 4'hF; rdy = 1'b1; end
        2: rdy = ($urandom_range(0, 15) == 0);
        3: r = 4'b0100;
        4: r = 4'($urandom & $urandom);
        default: ;
      endcase
      rs = !(c < 3 || $urandom_range(0, 299) == 0);
      rst_n = rs;
      if4.request_i = r;      if4.s_last_i = l;
      if3.request_i = r[2:0]; if3.s_last_i = l[2:0];
      if4.m_ready_i = rdy;    if3.m_ready_i = rdy;
      model_step(0, rs, r, l, rdy);
      model_step(1, rs, {1'b0, r[2:0]}, {1'b0, l[2:0]}, rdy);
    end
    w = 0;
    while (q.size() > 0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
